// File: rtl/vga_pkg.sv
// Default 640x480@60 timing constants and the sync bundle carried through the delay line.
package vga_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic blank_n;
    } sync_t;

    // Idle raster level: both syncs deasserted, video blanked.
    localparam sync_t SYNC_IDLE = '{hsync: 1'b1, vsync: 1'b1, blank_n: 1'b0};

endpackage

// File: rtl/pixel_delay_line.sv
// Shift register advanced once per pixel slot; reset loads every stage with a fill value.
module pixel_delay_line #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_fill,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= i_fill;
            end
        end else if (i_en) begin
            r_stage[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster generator: pixel-slot divider, h/v counters, and sync/blank delayed to match
// the sprite pipeline latency.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int CLK_DIV  = 2,
    parameter int PIPE_DLY = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    output logic       o_pix_en,
    output logic [9:0] o_posx,
    output logic [9:0] o_posy,
    output logic       o_active,
    output logic       o_line_start,
    output logic       o_frame_start,
    output logic       o_hsync,
    output logic       o_vsync,
    output logic       o_blank_n
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [2:0] DIV_LAST = 3'(CLK_DIV - 1);

    if (H_TOTAL > 1024) begin : g_h_range
        $error("vga_timing_gen: H_TOTAL does not fit the 10-bit column counter");
    end
    if (V_TOTAL > 1024) begin : g_v_range
        $error("vga_timing_gen: V_TOTAL does not fit the 10-bit line counter");
    end
    if (CLK_DIV < 1 || CLK_DIV > 8) begin : g_div_range
        $error("vga_timing_gen: CLK_DIV must be 1..8");
    end
    if (PIPE_DLY < 1 || PIPE_DLY > 4) begin : g_dly_range
        $error("vga_timing_gen: PIPE_DLY must be 1..4");
    end

    logic [2:0] r_div;
    logic       r_pix_en;
    logic [9:0] r_posx;
    logic [9:0] r_posy;
    logic       r_active;
    logic       r_line_start;
    logic       r_frame_start;

    logic [2:0] w_div_nxt;
    logic       w_pix_en_nxt;
    logic [9:0] w_posx_nxt;
    logic [9:0] w_posy_nxt;
    logic       w_line_start_nxt;
    sync_t      w_raw;
    sync_t      w_dly;

    // Strobes and active are computed from the next position so that, once registered,
    // they describe the slot that posx/posy are currently showing.
    always_comb begin
        w_div_nxt    = (r_div == DIV_LAST) ? 3'd0 : r_div + 3'd1;
        w_pix_en_nxt = (w_div_nxt == DIV_LAST);
        w_posx_nxt   = r_posx;
        w_posy_nxt   = r_posy;
        if (r_pix_en) begin
            if (r_posx == H_LAST) begin
                w_posx_nxt = 10'd0;
                w_posy_nxt = (r_posy == V_LAST) ? 10'd0 : r_posy + 10'd1;
            end else begin
                w_posx_nxt = r_posx + 10'd1;
            end
        end
        w_line_start_nxt = w_pix_en_nxt && (w_posx_nxt == 10'd0);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_div         <= 3'd0;
            r_pix_en      <= 1'b0;
            r_posx        <= 10'd0;
            r_posy        <= 10'd0;
            r_active      <= 1'b1;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_div         <= w_div_nxt;
            r_pix_en      <= w_pix_en_nxt;
            r_posx        <= w_posx_nxt;
            r_posy        <= w_posy_nxt;
            r_active      <= (w_posx_nxt < H_ACT) && (w_posy_nxt < V_ACT);
            r_line_start  <= w_line_start_nxt;
            r_frame_start <= w_line_start_nxt && (w_posy_nxt == 10'd0);
        end
    end

    always_comb begin
        w_raw.hsync   = !((r_posx >= HS_START) && (r_posx <= HS_END));
        w_raw.vsync   = !((r_posy >= VS_START) && (r_posy <= VS_END));
        w_raw.blank_n = r_active;
    end

    pixel_delay_line #(
        .DEPTH (PIPE_DLY),
        .WIDTH ($bits(sync_t))
    ) u_sync_dly (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_en   (r_pix_en),
        .i_fill (SYNC_IDLE),
        .i_d    (w_raw),
        .o_q    (w_dly)
    );

    assign o_pix_en      = r_pix_en;
    assign o_posx        = r_posx;
    assign o_posy        = r_posy;
    assign o_active      = r_active;
    assign o_line_start  = r_line_start;
    assign o_frame_start = r_frame_start;
    assign o_hsync       = w_dly.hsync;
    assign o_vsync       = w_dly.vsync;
    assign o_blank_n     = w_dly.blank_n;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default-timing instance plus two reduced-raster instances for frame-level corners.
module tb_vga_timing_gen;

    logic clk;
    logic rst;
    logic rst_s;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic       d_pix_en, d_active, d_line_start, d_frame_start, d_hsync, d_vsync, d_blank_n;
    logic [9:0] d_posx, d_posy;
    logic       s_pix_en, s_active, s_line_start, s_frame_start, s_hsync, s_vsync, s_blank_n;
    logic [9:0] s_posx, s_posy;
    logic       f_pix_en, f_active, f_line_start, f_frame_start, f_hsync, f_vsync, f_blank_n;
    logic [9:0] f_posx, f_posy;

    vga_timing_gen dut (
        .i_clk(clk), .i_rst(rst), .o_pix_en(d_pix_en), .o_posx(d_posx), .o_posy(d_posy),
        .o_active(d_active), .o_line_start(d_line_start), .o_frame_start(d_frame_start),
        .o_hsync(d_hsync), .o_vsync(d_vsync), .o_blank_n(d_blank_n)
    );

    // Small raster: H_TOTAL=15 (hsync raw [10,12]), V_TOTAL=8 (vsync raw [5,6]).
    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .CLK_DIV(2), .PIPE_DLY(2)
    ) dut_s (
        .i_clk(clk), .i_rst(rst_s), .o_pix_en(s_pix_en), .o_posx(s_posx), .o_posy(s_posy),
        .o_active(s_active), .o_line_start(s_line_start), .o_frame_start(s_frame_start),
        .o_hsync(s_hsync), .o_vsync(s_vsync), .o_blank_n(s_blank_n)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .CLK_DIV(1), .PIPE_DLY(1)
    ) dut_f (
        .i_clk(clk), .i_rst(rst_s), .o_pix_en(f_pix_en), .o_posx(f_posx), .o_posy(f_posy),
        .o_active(f_active), .o_line_start(f_line_start), .o_frame_start(f_frame_start),
        .o_hsync(f_hsync), .o_vsync(f_vsync), .o_blank_n(f_blank_n)
    );

    int checks = 0;
    int errors = 0;
    int cur_k  = 0;

    typedef struct {
        int k;
        int posx;
        int posy;
        bit pix_en;
        bit frame_start;
        bit line_start;
        bit active;
        bit hsync;
        bit blank_n;
    } vec_t;

    // k counts clk cycles since the last reset edge (k=0 is the first cycle with rst low).
    vec_t vecs [17] = '{
        '{0,    0,   0, 0, 0, 0, 1, 1, 0},
        '{1,    0,   0, 1, 1, 1, 1, 1, 0},
        '{2,    1,   0, 0, 0, 0, 1, 1, 0},
        '{3,    1,   0, 1, 0, 0, 1, 1, 0},
        '{4,    2,   0, 0, 0, 0, 1, 1, 1},
        '{1279, 639, 0, 1, 0, 0, 1, 1, 1},
        '{1280, 640, 0, 0, 0, 0, 0, 1, 1},
        '{1282, 641, 0, 0, 0, 0, 0, 1, 1},
        '{1284, 642, 0, 0, 0, 0, 0, 1, 0},
        '{1314, 657, 0, 0, 0, 0, 0, 1, 0},
        '{1316, 658, 0, 0, 0, 0, 0, 0, 0},
        '{1506, 753, 0, 0, 0, 0, 0, 0, 0},
        '{1508, 754, 0, 0, 0, 0, 0, 1, 0},
        '{1599, 799, 0, 1, 0, 0, 0, 1, 0},
        '{1600, 0,   1, 0, 0, 0, 1, 1, 0},
        '{1601, 0,   1, 1, 0, 1, 1, 1, 0},
        '{1604, 2,   1, 0, 0, 0, 1, 1, 1}
    };

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic advance(input int target);
        while (cur_k < target) begin
            @(posedge clk);
            #1;
            cur_k++;
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cur_k = 0;
    endtask

    initial begin
        int s_fs0, s_fs1, f_fs0, f_fs1;
        int s_vs_low, f_vs_low, s_hs_low, f_hs_low, s_hs_first, f_hs_first, f_pix_gaps;
        logic [13:0] exp_scan;

        rst   = 1'b1;
        rst_s = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_pix_en",      d_pix_en,      0);
        chk("rst_posx",        d_posx,        0);
        chk("rst_posy",        d_posy,        0);
        chk("rst_hsync",       d_hsync,       1);
        chk("rst_vsync",       d_vsync,       1);
        chk("rst_blank_n",     d_blank_n,     0);
        chk("rst_line_start",  d_line_start,  0);
        chk("rst_frame_start", d_frame_start, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_frozen_posx", d_posx,   0);
        chk("rst_frozen_pix",  d_pix_en, 0);

        rst   = 1'b0;
        cur_k = 0;
        foreach (vecs[i]) begin
            advance(vecs[i].k);
            chk($sformatf("vec%0d_posx", i),        d_posx,        vecs[i].posx);
            chk($sformatf("vec%0d_posy", i),        d_posy,        vecs[i].posy);
            chk($sformatf("vec%0d_pix_en", i),      d_pix_en,      vecs[i].pix_en);
            chk($sformatf("vec%0d_frame_start", i), d_frame_start, vecs[i].frame_start);
            chk($sformatf("vec%0d_line_start", i),  d_line_start,  vecs[i].line_start);
            chk($sformatf("vec%0d_active", i),      d_active,      vecs[i].active);
            chk($sformatf("vec%0d_hsync", i),       d_hsync,       vecs[i].hsync);
            chk($sformatf("vec%0d_blank_n", i),     d_blank_n,     vecs[i].blank_n);
        end

        // Whole of line 2, sampled on each pix_en: {posx, posy==2, line_start, hsync, blank_n}
        for (int s = 0; s < 800; s++) begin
            advance(3200 + 2 * s + 1);
            exp_scan = {10'(s), 1'b1, (s == 0), !(s >= 658 && s <= 753), (s >= 2 && s < 642)};
            chk($sformatf("line2_slot%0d", s),
                {d_posx, (d_posy == 10'd2), d_line_start, d_hsync, d_blank_n}, exp_scan);
        end

        // Reset in the active region: blank_n must drop back to the fill value.
        advance(5400);
        chk("mid1_pre_posx",    d_posx,    300);
        chk("mid1_pre_blank_n", d_blank_n, 1);
        pulse_reset();
        chk("mid1_k0_posx",     d_posx,    0);
        chk("mid1_k0_posy",     d_posy,    0);
        chk("mid1_k0_pix_en",   d_pix_en,  0);
        chk("mid1_k0_blank_n",  d_blank_n, 0);
        advance(1);
        chk("mid1_k1_frame_start", d_frame_start, 1);
        chk("mid1_k1_blank_n",     d_blank_n,     0);
        advance(2);
        chk("mid1_k2_posx",    d_posx,    1);
        chk("mid1_k2_blank_n", d_blank_n, 0);
        advance(4);
        chk("mid1_k4_blank_n", d_blank_n, 1);

        // Reset inside hsync: hsync must return high for the first slots.
        advance(3000);
        chk("mid2_pre_posx",  d_posx,  700);
        chk("mid2_pre_posy",  d_posy,  1);
        chk("mid2_pre_hsync", d_hsync, 0);
        pulse_reset();
        chk("mid2_k0_hsync", d_hsync, 1);
        chk("mid2_k0_posx",  d_posx,  0);
        advance(1);
        chk("mid2_k1_hsync",       d_hsync,       1);
        chk("mid2_k1_frame_start", d_frame_start, 1);
        advance(3);
        chk("mid2_k3_hsync", d_hsync, 1);
        chk("mid2_k3_posx",  d_posx,  1);

        // Reduced rasters: frame wrap, frame period, sync widths, CLK_DIV=1/PIPE_DLY=1 sweep.
        s_fs0 = -1; s_fs1 = -1; f_fs0 = -1; f_fs1 = -1;
        s_vs_low = 0; f_vs_low = 0; s_hs_low = 0; f_hs_low = 0;
        s_hs_first = -1; f_hs_first = -1; f_pix_gaps = 0;
        rst_s = 1'b0;
        for (int k = 0; k < 600; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            if (s_frame_start) begin
                if (s_fs0 < 0) s_fs0 = k;
                else if (s_fs1 < 0) s_fs1 = k;
            end
            if (f_frame_start) begin
                if (f_fs0 < 0) f_fs0 = k;
                else if (f_fs1 < 0) f_fs1 = k;
            end
            if (s_fs0 >= 0 && s_fs1 < 0 && !s_vsync) s_vs_low++;
            if (f_fs0 >= 0 && f_fs1 < 0 && !f_vsync) f_vs_low++;
            if (k < 30 && !s_hsync) begin
                s_hs_low++;
                if (s_hs_first < 0) s_hs_first = k;
            end
            if (k < 16 && !f_hsync) begin
                f_hs_low++;
                if (f_hs_first < 0) f_hs_first = k;
            end
            if (k >= 1 && !f_pix_en) f_pix_gaps++;
            case (k)
                0: begin
                    chk("f_k0_pix_en",  f_pix_en,  0);
                    chk("f_k0_blank_n", f_blank_n, 0);
                    chk("s_k0_hsync",   s_hsync,   1);
                end
                1: chk("f_k1_blank_n", f_blank_n, 0);
                2: begin
                    chk("f_k2_posx",    f_posx,    1);
                    chk("f_k2_blank_n", f_blank_n, 1);
                end
                12: chk("f_k12_posx", f_posx, 11);
                120: begin
                    chk("f_wrap_posx",   f_posx,   14);
                    chk("f_wrap_posy",   f_posy,   7);
                    chk("f_wrap_pix_en", f_pix_en, 1);
                end
                121: begin
                    chk("f_new_posx",        f_posx,        0);
                    chk("f_new_posy",        f_posy,        0);
                    chk("f_new_frame_start", f_frame_start, 1);
                end
                239: begin
                    chk("s_wrap_posx",   s_posx,   14);
                    chk("s_wrap_posy",   s_posy,   7);
                    chk("s_wrap_pix_en", s_pix_en, 1);
                end
                240: begin
                    chk("s_new_posx",   s_posx,   0);
                    chk("s_new_posy",   s_posy,   0);
                    chk("s_new_pix_en", s_pix_en, 0);
                end
                241: begin
                    chk("s_new_frame_start", s_frame_start, 1);
                    chk("s_new_line_start",  s_line_start,  1);
                end
                default: ;
            endcase
        end
        chk("s_first_frame_start", s_fs0,         1);
        chk("s_frame_period",      s_fs1 - s_fs0, 240);
        chk("s_vsync_low_clk",     s_vs_low,      60);
        chk("s_hsync_low_clk",     s_hs_low,      6);
        chk("s_hsync_first_k",     s_hs_first,    24);
        chk("f_first_frame_start", f_fs0,         1);
        chk("f_frame_period",      f_fs1 - f_fs0, 120);
        chk("f_vsync_low_clk",     f_vs_low,      30);
        chk("f_hsync_low_clk",     f_hs_low,      3);
        chk("f_hsync_first_k",     f_hs_first,    12);
        chk("f_pix_en_gaps",       f_pix_gaps,    0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
